// File: rtl/reg_file_sb.sv
// Register file with write-through forwarding, a sequential clear engine and an
// optional pending-write scoreboard (enable with `define REGFILE_SCOREBOARD_EN).
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [READ_PORTS-1:0]            read_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_busy,
  input  logic                             write_en,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             issue_en,
  input  logic [ADDR_WIDTH-1:0]            issue_addr,
  input  logic                             clear_req,
  output logic                             ready
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  // NOTE: non-blocking assignments for all sequential state so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_idx <= ADDR_WIDTH'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= ADDR_WIDTH'(1);
            ready   <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; the clear engine zeroes it entry by
  // entry, which keeps it mappable onto RAM/flop arrays without reset fan-out.
  // Entry 0 is never written and never read: reads of r0 are forced to zero.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[clr_idx] <= '0;
    end else if (write_en && write_addr != '0) begin
      regs[write_addr] <= write_data;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;

  // NOTE: the issue set follows the write clear, so when both target the same
  // bit the later non-blocking assignment (the new producer) wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else if (state == CLEAR || clear_req) begin
      busy <= '0;
    end else begin
      if (write_en) busy[write_addr] <= 1'b0;
      if (issue_en && issue_addr != '0) busy[issue_addr] <= 1'b1;
    end
  end
`else
  logic unused_issue;
  assign unused_issue = ^{issue_en, issue_addr};
`endif

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = write_en && (write_addr == addr);

    // A same-cycle writeback is forwarded ahead of the stored value.
    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] =
        (!ready || !read_en[p] || addr == '0) ? '0 :
        hit                                   ? write_data :
                                                regs[addr];

`ifdef REGFILE_SCOREBOARD_EN
    assign read_busy[p] = ready && read_en[p] && busy[addr] && !hit;
`else
    assign read_busy[p] = 1'b0;
`endif
  end

endmodule
